sram_port_arbiter: RTL and testbench



---
 rtl/sram_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Arbiter for the single-port instruction/data SRAM: fetch, LSU and custom engine
// share one ram_1p through req/gnt/rvalid handshakes with aging and range checking.
module sram_port_arbiter #(
  parameter int unsigned MemSize  = 262144,
  parameter logic [31:0] MemStart = 32'h0000_0000,
  parameter int unsigned MaxWait  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  input  logic        cust_req_i,
  input  logic        cust_we_i,
  input  logic [31:0] cust_addr_i,
  input  logic [31:0] cust_wdata_i,
  output logic        cust_gnt_o,
  output logic        cust_rvalid_o,
  output logic [31:0] cust_rdata_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    PORT_INSTR = 2'd0,
    PORT_DATA  = 2'd1,
    PORT_CUST  = 2'd2
  } port_e;

  localparam logic [31:0] AddrMask = ~(32'(MemSize) - 32'd1);
  localparam logic [3:0]  WaitMax  = 4'(MaxWait);

  logic [3:0]  wait_d, wait_c;
  logic        urg_d, urg_c;
  logic        any_gnt;
  port_e       sel;
  logic [31:0] sel_addr, sel_wdata;
  logic        sel_we;
  logic [3:0]  sel_be;
  logic        in_range;

  logic        rsp_valid_q, rsp_err_q;
  port_e       rsp_owner_q;

  // Urgent ports pre-empt the base instr > data > cust order.
  always_comb begin
    urg_d       = data_req_i && (wait_d == WaitMax);
    urg_c       = cust_req_i && (wait_c == WaitMax);
    any_gnt     = 1'b0;
    sel         = PORT_INSTR;
    instr_gnt_o = 1'b0;
    data_gnt_o  = 1'b0;
    cust_gnt_o  = 1'b0;
    if (!rst_i) begin
      if (urg_d) begin
        data_gnt_o = 1'b1;
        sel        = PORT_DATA;
      end else if (urg_c) begin
        cust_gnt_o = 1'b1;
        sel        = PORT_CUST;
      end else if (instr_req_i) begin
        instr_gnt_o = 1'b1;
        sel         = PORT_INSTR;
      end else if (data_req_i) begin
        data_gnt_o = 1'b1;
        sel        = PORT_DATA;
      end else if (cust_req_i) begin
        cust_gnt_o = 1'b1;
        sel        = PORT_CUST;
      end
      any_gnt = instr_gnt_o | data_gnt_o | cust_gnt_o;
    end
  end

  always_comb begin
    sel_addr  = instr_addr_i;
    sel_wdata = '0;
    sel_we    = 1'b0;
    sel_be    = '1;
    case (sel)
      PORT_DATA: begin
        sel_addr  = data_addr_i;
        sel_wdata = data_wdata_i;
        sel_we    = data_we_i;
        sel_be    = data_be_i;
      end
      PORT_CUST: begin
        sel_addr  = cust_addr_i;
        sel_wdata = cust_wdata_i;
        sel_we    = cust_we_i;
      end
      default: ;
    endcase
  end

  assign in_range    = (sel_addr & AddrMask) == MemStart;
  assign mem_req_o   = any_gnt && in_range;
  assign mem_we_o    = mem_req_o && sel_we;
  assign mem_be_o    = mem_req_o ? sel_be    : '0;
  assign mem_addr_o  = mem_req_o ? sel_addr  : '0;
  assign mem_wdata_o = mem_req_o ? sel_wdata : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_d <= '0;
      wait_c <= '0;
    end else begin
      if (!data_req_i || data_gnt_o) wait_d <= '0;
      else if (wait_d != WaitMax)    wait_d <= wait_d + 4'd1;
      if (!cust_req_i || cust_gnt_o) wait_c <= '0;
      else if (wait_c != WaitMax)    wait_c <= wait_c + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= PORT_INSTR;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= any_gnt;
      rsp_owner_q <= sel;
      rsp_err_q   <= any_gnt && !in_range;
    end
  end

  // Gating with rst_i drops a response already registered when reset arrives.
  always_comb begin
    instr_rvalid_o = rsp_valid_q && !rst_i && (rsp_owner_q == PORT_INSTR);
    data_rvalid_o  = rsp_valid_q && !rst_i && (rsp_owner_q == PORT_DATA);
    cust_rvalid_o  = rsp_valid_q && !rst_i && (rsp_owner_q == PORT_CUST);
    instr_err_o    = instr_rvalid_o && rsp_err_q;
    data_err_o     = data_rvalid_o && rsp_err_q;
    instr_rdata_o  = (instr_rvalid_o && !rsp_err_q) ? mem_rdata_i : '0;
    data_rdata_o   = (data_rvalid_o  && !rsp_err_q) ? mem_rdata_i : '0;
    cust_rdata_o   = (cust_rvalid_o  && !rsp_err_q) ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with an SRAM model and a response scoreboard.
module tb_sram_port_arbiter;

  localparam logic [31:0] MEM_START = 32'h0000_0000;
  localparam int unsigned MEM_SIZE  = 262144;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_we, data_gnt, data_rvalid, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        cust_req, cust_we, cust_gnt, cust_rvalid;
  logic [31:0] cust_addr, cust_wdata, cust_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  sram_port_arbiter #(.MemSize(MEM_SIZE), .MemStart(MEM_START), .MaxWait(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_rdata_o(data_rdata), .data_err_o(data_err),
    .cust_req_i(cust_req), .cust_we_i(cust_we), .cust_addr_i(cust_addr),
    .cust_wdata_i(cust_wdata), .cust_gnt_o(cust_gnt), .cust_rvalid_o(cust_rvalid),
    .cust_rdata_o(cust_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // SRAM environment model (read-before-write, rdata held between accesses)
  logic [31:0] ram     [65536];
  logic [31:0] ref_mem [65536];

  always @(posedge clk) begin
    if (mem_req) begin
      mem_rdata <= ram[mem_addr[17:2]];
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[17:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
  } rsp_t;
  rsp_t sb[$];

  task automatic push(input int port, input logic [31:0] addr, input logic we,
                      input logic [3:0] be, input logic [31:0] wdata);
    rsp_t e;
    logic oor;
    oor    = !((longint'(addr) >= longint'(MEM_START)) &&
               (longint'(addr) <  longint'(MEM_START) + longint'(MEM_SIZE)));
    e.port = port;
    e.err  = (port == 2) ? 1'b0 : oor;
    e.data = oor ? 32'h0 : ref_mem[addr[17:2]];
    if (!oor && we)
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[addr[17:2]][8*b +: 8] = wdata[8*b +: 8];
    sb.push_back(e);
  endtask

  // Expectations are queued when a grant is seen, after inputs settle.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (instr_gnt) push(0, instr_addr, 1'b0, 4'hF, 32'h0);
      if (data_gnt)  push(1, data_addr, data_we, data_be, data_wdata);
      if (cust_gnt)  push(2, cust_addr, cust_we, 4'hF, cust_wdata);
    end
  end

  always @(negedge clk) begin
    int nv;
    int owner;
    logic [31:0] rd;
    logic er;
    rsp_t e;
    nv = int'(instr_rvalid) + int'(data_rvalid) + int'(cust_rvalid);
    if (rst) begin
      sb.delete();
      chk("rst_rvalid_count", nv, 0);
    end else if (nv != 0) begin
      chk("rvalid_count", nv, 1);
      chk("sb_pending", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e     = sb.pop_front();
        owner = instr_rvalid ? 0 : (data_rvalid ? 1 : 2);
        rd    = instr_rvalid ? instr_rdata : (data_rvalid ? data_rdata : cust_rdata);
        er    = instr_rvalid ? instr_err : (data_rvalid ? data_err : 1'b0);
        chk("rsp_owner", owner, e.port);
        chk("rsp_rdata", rd, e.data);
        chk("rsp_err", er, e.err);
      end
    end
    if (!instr_rvalid) chk("idle_instr", {instr_rdata[30:0], instr_err}, 32'h0);
    if (!data_rvalid)  chk("idle_data", {data_rdata[30:0], data_err}, 32'h0);
    if (!cust_rvalid)  chk("idle_cust", cust_rdata, 32'h0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    instr_req = 1'b0; data_req = 1'b0; cust_req = 1'b0;
    data_we = 1'b0; cust_we = 1'b0; data_be = 4'hF;
  endtask

  initial begin
    int cust_first;
    logic [2:0] g;
    rst = 1'b1;
    idle();
    instr_addr = '0; data_addr = '0; data_wdata = '0; cust_addr = '0; cust_wdata = '0;
    mem_rdata = '0;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    ram[16'h40] = 32'hDEADBEEF; ref_mem[16'h40] = 32'hDEADBEEF;
    ram[16'h04] = 32'hCAFE0010; ref_mem[16'h04] = 32'hCAFE0010;
    ram[16'h05] = 32'hCAFE0014; ref_mem[16'h05] = 32'hCAFE0014;

    // Reset: requests present but nothing granted
    step();
    instr_req = 1'b1; data_req = 1'b1; cust_req = 1'b1;
    #1;
    chk("rst_gnts", {instr_gnt, data_gnt, cust_gnt}, 3'b000);
    chk("rst_mem_req", mem_req, 1'b0);
    step();
    chk("rst_rvalids", {instr_rvalid, data_rvalid, cust_rvalid}, 3'b000);
    rst = 1'b0;
    idle();
    step();

    // Single instruction read
    instr_req = 1'b1; instr_addr = 32'h100;
    #1;
    chk("t1_gnt", instr_gnt, 1'b1);
    chk("t1_mem", {mem_req, mem_we, mem_be}, {1'b1, 1'b0, 4'hF});
    chk("t1_addr", mem_addr, 32'h100);
    step();
    idle();
    chk("t1_rvalid", instr_rvalid, 1'b1);
    chk("t1_rdata", instr_rdata, 32'hDEADBEEF);
    chk("t1_err", instr_err, 1'b0);

    // Partial data write then full-word custom read
    step();
    data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011;
    data_addr = 32'h200; data_wdata = 32'h12345678;
    #1;
    chk("t2_gnt", data_gnt, 1'b1);
    chk("t2_be", mem_be, 4'b0011);
    chk("t2_we", mem_we, 1'b1);
    chk("t2_wdata", mem_wdata, 32'h12345678);
    step();
    idle();
    chk("t2_rvalid", data_rvalid, 1'b1);
    cust_req = 1'b1; cust_we = 1'b0; cust_addr = 32'h200;
    #1;
    chk("t2_cgnt", cust_gnt, 1'b1);
    chk("t2_cmem", {mem_req, mem_we, mem_be}, {1'b1, 1'b0, 4'hF});
    step();
    idle();
    chk("t2_crvalid", cust_rvalid, 1'b1);
    chk("t2_crdata", cust_rdata, 32'h00005678);

    // Out-of-range data read and custom write
    step();
    data_req = 1'b1; data_addr = 32'h0004_0000;
    #1;
    chk("t3_gnt", data_gnt, 1'b1);
    chk("t3_mem_req", mem_req, 1'b0);
    step();
    idle();
    chk("t3_rvalid", data_rvalid, 1'b1);
    chk("t3_err", data_err, 1'b1);
    chk("t3_rdata", data_rdata, 32'h0);
    cust_req = 1'b1; cust_we = 1'b1; cust_addr = 32'h0004_0200; cust_wdata = 32'hFFFF_FFFF;
    #1;
    chk("t3_cgnt", cust_gnt, 1'b1);
    chk("t3_cmem_req", mem_req, 1'b0);
    step();
    idle();
    chk("t3_crvalid", cust_rvalid, 1'b1);
    chk("t3_ram_untouched", ram[16'h80], 32'h00005678);

    // Back-to-back data reads
    step();
    data_req = 1'b1; data_addr = 32'h10;
    #1;
    chk("t4_gnt0", data_gnt, 1'b1);
    step();
    chk("t4_rv0", data_rvalid, 1'b1);
    chk("t4_rd0", data_rdata, 32'hCAFE0010);
    data_addr = 32'h14;
    #1;
    chk("t4_gnt1", data_gnt, 1'b1);
    step();
    idle();
    chk("t4_rv1", data_rvalid, 1'b1);
    chk("t4_rd1", data_rdata, 32'hCAFE0014);
    step();

    // Contention: all three held, aging must break instr's hold
    instr_req = 1'b1; instr_addr = 32'h100;
    data_req  = 1'b1; data_addr  = 32'h10;
    cust_req  = 1'b1; cust_addr  = 32'h14;
    cust_first = -1;
    for (int c = 0; c < 12; c++) begin
      #1;
      g = {cust_gnt, data_gnt, instr_gnt};
      chk($sformatf("t5_onehot_c%0d", c), $countones(g), 1);
      if (c < 4)  chk($sformatf("t5_instr_c%0d", c), g, 3'b001);
      if (c == 4) chk("t5_data_c4", g, 3'b010);
      if (cust_gnt && cust_first < 0) cust_first = c;
      step();
    end
    idle();
    chk("t5_cust_by_10", (cust_first >= 0) && (cust_first <= 10), 1'b1);
    step();
    step();

    // Reset the cycle after an instr grant
    instr_req = 1'b1; instr_addr = 32'h100;
    #1;
    chk("t6_gnt", instr_gnt, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    data_req = 1'b1; cust_req = 1'b1;
    #1;
    chk("t6_rst_gnts", {instr_gnt, data_gnt, cust_gnt}, 3'b000);
    chk("t6_rst_mem", mem_req, 1'b0);
    step();
    chk("t6_dropped", instr_rvalid, 1'b0);
    step();
    rst = 1'b0;
    idle();
    instr_req = 1'b1; instr_addr = 32'h100;
    #1;
    chk("t6_gnt_after", instr_gnt, 1'b1);
    step();
    idle();
    chk("t6_rvalid_after", instr_rvalid, 1'b1);
    chk("t6_rdata_after", instr_rdata, 32'hDEADBEEF);
    step();
    step();

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
